// File: rtl/instruction_decode_stage_pkg.sv
// puc_pkg: shared operand types, decoded bundle and field offsets
// for the registered instruction decode stage.
package puc_pkg;

  localparam int OPCODE_W = 6;
  localparam int ADDR_W   = 8;
  localparam int REG_W    = 3;

  typedef enum logic [1:0] {
    IMM = 2'd0,
    MEM = 2'd1,
    REG = 2'd2,
    IND = 2'd3
  } operand_type_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opCode;
    logic [ADDR_W-1:0]   address1In;
    logic [ADDR_W-1:0]   address2In;
    logic [ADDR_W-1:0]   addressOut;
    operand_type_e       address1Type;
    operand_type_e       address2Type;
    operand_type_e       outType;
    logic [REG_W-1:0]    register1In;
    logic [REG_W-1:0]    register2In;
    logic [REG_W-1:0]    registerOut;
    logic [2:0]          registerHasAddress;
    logic                dependsOnPrev;
  } decoded_t;

  function automatic int instr_width(
    input int ow,
    input int aw
  );
    return 2 + ow + 3 * aw + 8;
  endfunction

  // idx 0 = addressOut, 1 = address2, 2 = address1
  function automatic int addr_lsb(
    input int aw,
    input int idx
  );
    return 8 + idx * aw;
  endfunction

  function automatic int op_lsb(
    input int aw
  );
    return 8 + 3 * aw;
  endfunction

  function automatic logic reads_reg(
    input operand_type_e t
  );
    return (t == REG) || (t == IND);
  endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode
// stage and the operand-fetch consumer.
interface instruction_decode_stage_if
  import puc_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int REG_BITS     = REG_W,
  parameter int DEPTH        = 2
) ();

  localparam int INSTRUCTION_WIDTH =
    instr_width(OPCODE_WIDTH, ADDR_WIDTH);
  localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

  logic                         flush;
  logic                         inValid;
  logic                         inReady;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         outValid;
  logic                         outReady;
  logic [OPCODE_WIDTH-1:0]      opCode;
  logic [ADDR_WIDTH-1:0]        address1In;
  logic [ADDR_WIDTH-1:0]        address2In;
  logic [ADDR_WIDTH-1:0]        addressOut;
  logic [1:0]                   address1Type;
  logic [1:0]                   address2Type;
  logic [1:0]                   outType;
  logic [REG_BITS-1:0]          register1In;
  logic [REG_BITS-1:0]          register2In;
  logic [REG_BITS-1:0]          registerOut;
  logic [2:0]                   registerHasAddress;
  logic [ADDR_WIDTH-1:0]        instructionValue;
  logic                         dependsOnPrev;
  logic [COUNT_WIDTH-1:0]       count;

  modport master (
    output flush, inValid, instruction, outReady,
    input  inReady, outValid, opCode,
    input  address1In, address2In, addressOut,
    input  address1Type, address2Type, outType,
    input  register1In, register2In, registerOut,
    input  registerHasAddress, instructionValue,
    input  dependsOnPrev, count
  );

  modport slave (
    input  flush, inValid, instruction, outReady,
    output inReady, outValid, opCode,
    output address1In, address2In, addressOut,
    output address1Type, address2Type, outType,
    output register1In, register2In, registerOut,
    output registerHasAddress, instructionValue,
    output dependsOnPrev, count
  );

endinterface

// File: rtl/instruction_decode_stage_sync_fifo.sv
// sync_fifo: pointer-based FIFO with flush; storage is cleared on
// reset so the head reads as zero after reset.
module sync_fifo #(
  parameter int WIDTH = $bits(puc_pkg::decoded_t),
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = count == (PW+1)'(DEPTH);
  assign valid   = count != '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid && !flush;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: slices raw instructions into fields,
// tags RAW hazards against the previous accept, buffers in a FIFO.
module instruction_decode_stage
  import puc_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int REG_BITS     = REG_W,
  parameter int DEPTH        = 2
) (
  input logic clock,
  input logic reset,
  instruction_decode_stage_if.slave bus
);

  localparam int IW = instr_width(OPCODE_WIDTH, ADDR_WIDTH);
  localparam int AO = addr_lsb(ADDR_WIDTH, 0);
  localparam int A2 = addr_lsb(ADDR_WIDTH, 1);
  localparam int A1 = addr_lsb(ADDR_WIDTH, 2);
  localparam int OP = op_lsb(ADDR_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opCode;
    logic [ADDR_WIDTH-1:0]   address1In;
    logic [ADDR_WIDTH-1:0]   address2In;
    logic [ADDR_WIDTH-1:0]   addressOut;
    operand_type_e           address1Type;
    operand_type_e           address2Type;
    operand_type_e           outType;
    logic [REG_BITS-1:0]     register1In;
    logic [REG_BITS-1:0]     register2In;
    logic [REG_BITS-1:0]     registerOut;
    logic [2:0]              registerHasAddress;
    logic                    dependsOnPrev;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  logic [IW-1:0]       ins;
  bundle_t             dec;
  bundle_t             head;
  logic [BW-1:0]       head_bits;
  logic                full;
  logic                in_ready;
  logic                out_valid;
  logic                accept;
  logic                pop;
  logic [CW-1:0]       cnt;
  logic                prev_valid;
  logic [REG_BITS-1:0] prev_dest;
  logic                unused_reserved;

  assign ins             = bus.instruction;
  assign unused_reserved = ins[7];

  always_comb begin
    dec              = '0;
    dec.opCode       = ins[OP +: OPCODE_WIDTH];
    dec.address1In   = ins[A1 +: ADDR_WIDTH];
    dec.address2In   = ins[A2 +: ADDR_WIDTH];
    dec.addressOut   = ins[AO +: ADDR_WIDTH];
    dec.address1Type = operand_type_e'(ins[5:4]);
    dec.address2Type = operand_type_e'(ins[3:2]);
    dec.outType      = operand_type_e'(ins[1:0]);
    dec.register1In  = dec.address1In[REG_BITS-1:0];
    dec.register2In  = dec.address2In[REG_BITS-1:0];
    dec.registerOut  = dec.addressOut[REG_BITS-1:0];
    dec.registerHasAddress =
      {ins[IW-1], ins[IW-2], ins[6]};
    // hazard is judged against history before this accept lands
    dec.dependsOnPrev = prev_valid && (
      (reads_reg(dec.address1Type) &&
       dec.register1In == prev_dest) ||
      (reads_reg(dec.address2Type) &&
       dec.register2In == prev_dest));
  end

  assign in_ready = !reset && !bus.flush && !full;
  assign accept   = bus.inValid && in_ready;
  assign pop      = out_valid && bus.outReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_valid <= 1'b0;
      prev_dest  <= '0;
    end else if (bus.flush) begin
      prev_valid <= 1'b0;
    end else if (accept) begin
      prev_valid <= dec.outType == REG;
      prev_dest  <= dec.registerOut;
    end
  end

  sync_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (bus.flush),
    .push  (accept),
    .din   (dec),
    .pop   (pop),
    .dout  (head_bits),
    .valid (out_valid),
    .full  (full),
    .count (cnt)
  );

  assign head = bundle_t'(head_bits);

  assign bus.inReady            = in_ready;
  assign bus.outValid           = out_valid;
  assign bus.count              = cnt;
  assign bus.opCode             = head.opCode;
  assign bus.address1In         = head.address1In;
  assign bus.address2In         = head.address2In;
  assign bus.addressOut         = head.addressOut;
  assign bus.address1Type       = head.address1Type;
  assign bus.address2Type       = head.address2Type;
  assign bus.outType            = head.outType;
  assign bus.register1In        = head.register1In;
  assign bus.register2In        = head.register2In;
  assign bus.registerOut        = head.registerOut;
  assign bus.registerHasAddress = head.registerHasAddress;
  assign bus.instructionValue   = head.address2In;
  assign bus.dependsOnPrev      = head.dependsOnPrev;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage: directed vectors plus hand-built
// backpressure, streaming, flush and reset sequences.
module tb_instruction_decode_stage;
  import puc_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  instruction_decode_stage_if bus ();

  instruction_decode_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [39:0] instr;
    decoded_t    exp;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [39:0] mki(
    input logic [1:0] fl, input logic [5:0] op,
    input logic [7:0] a1, input logic [7:0] a2,
    input logic [7:0] ao, input logic [7:0] lo
  );
    return {fl, op, a1, a2, ao, lo};
  endfunction

  function automatic decoded_t mk(
    input logic [5:0] op, input logic [7:0] a1,
    input logic [7:0] a2, input logic [7:0] ao,
    input operand_type_e t1, input operand_type_e t2,
    input operand_type_e to, input logic [2:0] r1,
    input logic [2:0] r2, input logic [2:0] ro,
    input logic [2:0] rha, input logic dep
  );
    decoded_t d;
    d.opCode = op;
    d.address1In = a1;
    d.address2In = a2;
    d.addressOut = ao;
    d.address1Type = t1;
    d.address2Type = t2;
    d.outType = to;
    d.register1In = r1;
    d.register2In = r2;
    d.registerOut = ro;
    d.registerHasAddress = rha;
    d.dependsOnPrev = dep;
    return d;
  endfunction

  function automatic decoded_t got_bundle();
    decoded_t d;
    d.opCode = bus.opCode;
    d.address1In = bus.address1In;
    d.address2In = bus.address2In;
    d.addressOut = bus.addressOut;
    d.address1Type = operand_type_e'(bus.address1Type);
    d.address2Type = operand_type_e'(bus.address2Type);
    d.outType = operand_type_e'(bus.outType);
    d.register1In = bus.register1In;
    d.register2In = bus.register2In;
    d.registerOut = bus.registerOut;
    d.registerHasAddress = bus.registerHasAddress;
    d.dependsOnPrev = bus.dependsOnPrev;
    return d;
  endfunction

  task automatic check(
    input string name,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, got, want);
    end
  endtask

  task automatic check_bundle(
    input string name,
    input decoded_t want
  );
    decoded_t g;
    g = got_bundle();
    checks++;
    if (g !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, g, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0].instr = mki(2'b10, 6'h05, 8'h0B, 8'h13, 8'h21, 8'h4A);
    vecs[0].exp = mk(6'h05, 8'h0B, 8'h13, 8'h21, IMM, REG, REG,
                     3'd3, 3'd3, 3'd1, 3'b101, 1'b0);
    vecs[1].instr = mki(2'b00, 6'h01, 8'h00, 8'h00, 8'h04, 8'h02);
    vecs[1].exp = mk(6'h01, 8'h00, 8'h00, 8'h04, IMM, IMM, REG,
                     3'd0, 3'd0, 3'd4, 3'b000, 1'b0);
    vecs[2].instr = mki(2'b01, 6'h02, 8'h0C, 8'h00, 8'h07, 8'h21);
    vecs[2].exp = mk(6'h02, 8'h0C, 8'h00, 8'h07, REG, IMM, MEM,
                     3'd4, 3'd0, 3'd7, 3'b010, 1'b1);
    vecs[3].instr = mki(2'b11, 6'h3F, 8'hFF, 8'h00, 8'h04, 8'h41);
    vecs[3].exp = mk(6'h3F, 8'hFF, 8'h00, 8'h04, IMM, IMM, MEM,
                     3'd7, 3'd0, 3'd4, 3'b111, 1'b0);
    vecs[4].instr = vecs[2].instr;
    vecs[4].exp = mk(6'h02, 8'h0C, 8'h00, 8'h07, REG, IMM, MEM,
                     3'd4, 3'd0, 3'd7, 3'b010, 1'b0);
    vecs[5].instr = mki(2'b00, 6'h10, 8'h00, 8'h00, 8'h0D, 8'h02);
    vecs[5].exp = mk(6'h10, 8'h00, 8'h00, 8'h0D, IMM, IMM, REG,
                     3'd0, 3'd0, 3'd5, 3'b000, 1'b0);
    vecs[6].instr = mki(2'b00, 6'h11, 8'h05, 8'h1D, 8'h00, 8'h1C);
    vecs[6].exp = mk(6'h11, 8'h05, 8'h1D, 8'h00, MEM, IND, IMM,
                     3'd5, 3'd5, 3'd0, 3'b000, 1'b1);
    vecs[7].instr = mki(2'b00, 6'h12, 8'h08, 8'h00, 8'h0A, 8'h22);
    vecs[7].exp = mk(6'h12, 8'h08, 8'h00, 8'h0A, REG, IMM, REG,
                     3'd0, 3'd0, 3'd2, 3'b000, 1'b0);
    vecs[8].instr = mki(2'b00, 6'h13, 8'h02, 8'h0A, 8'h00, 8'h12);
    vecs[8].exp = mk(6'h13, 8'h02, 8'h0A, 8'h00, MEM, IMM, REG,
                     3'd2, 3'd2, 3'd0, 3'b000, 1'b0);
    vecs[9].instr = mki(2'b00, 6'h14, 8'hF8, 8'h01, 8'h33, 8'h38);
    vecs[9].exp = mk(6'h14, 8'hF8, 8'h01, 8'h33, IND, REG, IMM,
                     3'd0, 3'd1, 3'd3, 3'b000, 1'b1);

    reset = 1'b1;
    bus.flush = 1'b0;
    bus.inValid = 1'b0;
    bus.outReady = 1'b0;
    bus.instruction = '0;
    #1;
    check_bundle("reset_fields", '0);
    check("reset_outValid", 32'(bus.outValid), 0);
    check("reset_count", 32'(bus.count), 0);
    check("reset_inReady", 32'(bus.inReady), 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("release_inReady", 32'(bus.inReady), 1);

    for (int i = 0; i < 10; i++) begin
      bus.instruction = vecs[i].instr;
      bus.inValid = 1'b1;
      tick();
      bus.inValid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(bus.outValid), 1);
      check_bundle($sformatf("vec%0d_fields", i), vecs[i].exp);
      check($sformatf("vec%0d_value", i),
            32'(bus.instructionValue),
            32'(vecs[i].exp.address2In));
      bus.outReady = 1'b1;
      tick();
      bus.outReady = 1'b0;
      check($sformatf("vec%0d_drain", i), 32'(bus.count), 0);
    end

    // backpressure: third push stalls until first pop
    bus.inValid = 1'b1;
    bus.instruction = mki(2'b00, 6'h21, 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    bus.instruction = mki(2'b00, 6'h22, 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    bus.instruction = mki(2'b00, 6'h23, 8'h0, 8'h0, 8'h0, 8'h0);
    check("bp_full_count", 32'(bus.count), 2);
    check("bp_full_inReady", 32'(bus.inReady), 0);
    tick();
    check("bp_stall_count", 32'(bus.count), 2);
    check("bp_stall_head", 32'(bus.opCode), 32'h21);
    bus.outReady = 1'b1;
    tick();
    check("bp_pop1_head", 32'(bus.opCode), 32'h22);
    check("bp_pop1_count", 32'(bus.count), 1);
    tick();
    bus.inValid = 1'b0;
    check("bp_pop2_head", 32'(bus.opCode), 32'h23);
    check("bp_pop2_count", 32'(bus.count), 1);
    tick();
    check("bp_empty", 32'(bus.outValid), 0);

    // streaming: one per cycle, no bubbles
    bus.inValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.instruction = mki(2'b00, 6'(48 + i),
                            8'h0, 8'(i), 8'h0, 8'h0);
      tick();
      check($sformatf("stream%0d_op", i),
            32'(bus.opCode), 32'(48 + i));
      check($sformatf("stream%0d_cnt", i),
            32'({bus.outValid, bus.count}), 32'h5);
    end
    bus.inValid = 1'b0;
    tick();
    check("stream_drain", 32'(bus.count), 0);

    // flush wipes entries and hazard history
    bus.outReady = 1'b0;
    bus.inValid = 1'b1;
    bus.instruction = mki(2'b00, 6'h01, 8'h0, 8'h0, 8'h00, 8'h00);
    tick();
    bus.instruction = mki(2'b00, 6'h02, 8'h0, 8'h0, 8'h0E, 8'h02);
    tick();
    check("fl_pre_count", 32'(bus.count), 2);
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    bus.instruction = mki(2'b00, 6'h03, 8'h0, 8'h0, 8'h0E, 8'h02);
    tick();
    check("fl_full_count", 32'(bus.count), 2);
    bus.flush = 1'b1;
    bus.instruction = mki(2'b00, 6'h2A, 8'h0, 8'h0, 8'h0, 8'h0);
    #1;
    check("fl_inReady", 32'(bus.inReady), 0);
    tick();
    bus.flush = 1'b0;
    bus.inValid = 1'b0;
    check("fl_count", 32'(bus.count), 0);
    check("fl_outValid", 32'(bus.outValid), 0);
    bus.inValid = 1'b1;
    bus.instruction = mki(2'b00, 6'h2B, 8'h06, 8'h0, 8'h0, 8'h20);
    tick();
    bus.inValid = 1'b0;
    check("fl_next_count", 32'(bus.count), 1);
    check("fl_next_op", 32'(bus.opCode), 32'h2B);
    check("fl_next_dep", 32'(bus.dependsOnPrev), 0);
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;

    // asynchronous reset mid-stream
    bus.inValid = 1'b1;
    bus.instruction = mki(2'b00, 6'h15, 8'h1, 8'h2, 8'h3, 8'h2A);
    tick();
    bus.inValid = 1'b0;
    check("rs_pre_count", 32'(bus.count), 1);
    #3;
    reset = 1'b1;
    #1;
    check_bundle("rs_fields", '0);
    check("rs_outValid", 32'(bus.outValid), 0);
    check("rs_count", 32'(bus.count), 0);
    check("rs_inReady", 32'(bus.inReady), 0);
    tick();
    reset = 1'b0;
    #1;
    check("rs_release_inReady", 32'(bus.inReady), 1);
    bus.inValid = 1'b1;
    bus.instruction = vecs[0].instr;
    tick();
    bus.inValid = 1'b0;
    check_bundle("rs_first_fields", vecs[0].exp);
    check("rs_first_valid", 32'(bus.outValid), 1);
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    check("rs_first_drain", 32'(bus.count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
